// File: rtl/in_port_strobe_rx_pkg.sv
// Shared constants for the CPU input-port strobe receiver.
package in_port_strobe_rx_pkg;

  localparam int WORD_WIDTH          = 32;
  localparam int IN_PORT_DEPTH       = 4;
  localparam int IN_PORT_SYNC_STAGES = 2;

endpackage

// File: rtl/in_port_strobe_rx_if.sv
// Strobe/data/read bus between the external source, the datapath and the receiver.
interface in_port_strobe_rx_if #(
  parameter int WIDTH = 32
);
  logic             strobe;
  logic [WIDTH-1:0] input_data;
  logic             InPortout;
  logic [WIDTH-1:0] BusMuxInInPortout;
  logic             in_valid;
  logic             in_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output strobe, input_data, InPortout,
    input  BusMuxInInPortout, in_valid, in_full, overflow, underflow
  );

  modport slave (
    input  strobe, input_data, InPortout,
    output BusMuxInInPortout, in_valid, in_full, overflow, underflow
  );
endinterface

// File: rtl/in_port_fifo.sv
// Small synchronous FIFO with combinational head read, last-popped hold and sticky error flags.
module in_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop at full frees the slot this push lands in.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_srst && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (i_push && w_full && !i_pop) begin
        r_overflow <= 1'b1;
      end
      if (i_pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_rdata     = w_empty ? r_last : r_mem[r_rd_ptr];
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/in_port_strobe_rx.sv
// Input-port receiver: synchronizes the source strobe, queues words, and serves the head to the bus mux.
module in_port_strobe_rx
  import in_port_strobe_rx_pkg::*;
#(
  parameter int WIDTH       = WORD_WIDTH,
  parameter int DEPTH       = IN_PORT_DEPTH,
  parameter int SYNC_STAGES = IN_PORT_SYNC_STAGES
) (
  input logic              Clock,
  input logic              clear,
  in_port_strobe_rx_if.slave port
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_sync_live;
  logic                   r_sync_prev;
  logic                   r_armed;
  logic                   r_rd_q;

  logic             w_sync_out;
  logic             w_sync_live;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;
  logic             w_empty;
  logic             w_full;
  logic             w_overflow;
  logic             w_underflow;

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_sync_live = r_sync_live[SYNC_STAGES-1];

  // r_sync_live marks when the chain holds real samples rather than reset zeros; a strobe
  // must be seen low after clear before its rising edge counts, so a held level never pushes.
  always_ff @(posedge Clock) begin
    if (clear) begin
      r_sync      <= '0;
      r_sync_live <= '0;
      r_sync_prev <= 1'b0;
      r_armed     <= 1'b0;
      r_rd_q      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], port.strobe};
      r_sync_live <= {r_sync_live[SYNC_STAGES-2:0], 1'b1};
      r_sync_prev <= w_sync_out;
      if (w_sync_live && !w_sync_out) begin
        r_armed <= 1'b1;
      end
      r_rd_q <= port.InPortout;
    end
  end

  assign w_push = w_sync_live & w_sync_out & ~r_sync_prev & r_armed;
  assign w_pop  = port.InPortout & ~r_rd_q;

  in_port_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (Clock),
    .i_srst      (clear),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (port.input_data),
    .o_rdata     (w_rdata),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_overflow  (w_overflow),
    .o_underflow (w_underflow)
  );

  assign port.BusMuxInInPortout = w_rdata;
  assign port.in_valid          = ~w_empty;
  assign port.in_full           = w_full;
  assign port.overflow          = w_overflow;
  assign port.underflow         = w_underflow;

endmodule

// File: tb/tb_in_port_strobe_rx.sv
// Directed bench for in_port_strobe_rx: reset, single word, fill/overflow, push+pop at full, underflow/wrap, long strobe.
module tb_in_port_strobe_rx;
  logic Clock;
  logic clear;
  int   n_total;
  int   n_bad;

  in_port_strobe_rx_if #(.WIDTH(32)) port ();

  in_port_strobe_rx #(
    .WIDTH       (32),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .Clock (Clock),
    .clear (clear),
    .port  (port)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(3);
  endtask

  // One-cycle strobe; data held until the push edge has passed.
  task automatic send(input logic [31:0] d);
    port.input_data = d;
    port.strobe     = 1'b1;
    step(1);
    port.strobe = 1'b0;
    step(3);
  endtask

  // Returns the bus value seen during the InPortout cycle.
  task automatic do_read(output logic [31:0] v);
    port.InPortout = 1'b1;
    #1;
    v = port.BusMuxInInPortout;
    @(posedge Clock);
    #1;
    port.InPortout = 1'b0;
    step(1);
  endtask

  logic [31:0] rv;

  initial begin
    n_total         = 0;
    n_bad           = 0;
    clear           = 1'b1;
    port.strobe     = 1'b1;
    port.input_data = 32'h0;
    port.InPortout  = 1'b0;

    // Reset with strobe held high: nothing pushes until strobe falls and rises again.
    step(2);
    clear = 1'b0;
    chk("rst_bus",   port.BusMuxInInPortout, 32'h0);
    chk("rst_valid", {31'b0, port.in_valid},  32'h0);
    chk("rst_full",  {31'b0, port.in_full},   32'h0);
    chk("rst_ovf",   {31'b0, port.overflow},  32'h0);
    chk("rst_unf",   {31'b0, port.underflow}, 32'h0);
    step(4);
    chk("held_strobe_no_push", {31'b0, port.in_valid}, 32'h0);
    port.strobe = 1'b0;
    step(4);
    chk("strobe_low_no_push", {31'b0, port.in_valid}, 32'h0);

    // Single word: visible after edge N+2, multi-cycle read pops once.
    port.input_data = 32'h0000FFFF;
    port.strobe     = 1'b1;
    step(1);
    port.strobe = 1'b0;
    chk("sw_valid_n",  {31'b0, port.in_valid}, 32'h0);
    step(1);
    chk("sw_valid_n1", {31'b0, port.in_valid}, 32'h0);
    step(1);
    chk("sw_valid_n2", {31'b0, port.in_valid}, 32'h1);
    chk("sw_bus",      port.BusMuxInInPortout, 32'h0000FFFF);
    port.InPortout = 1'b1;
    step(3);
    port.InPortout = 1'b0;
    step(1);
    chk("sw_after_valid", {31'b0, port.in_valid},  32'h0);
    chk("sw_after_bus",   port.BusMuxInInPortout,  32'h0000FFFF);
    chk("sw_after_unf",   {31'b0, port.underflow}, 32'h0);

    // Fill to full, then one more strobe overflows and is dropped.
    for (int i = 1; i <= 4; i++) send(32'(i));
    chk("fill_full", {31'b0, port.in_full},  32'h1);
    chk("fill_ovf0", {31'b0, port.overflow}, 32'h0);
    send(32'd5);
    chk("fill_ovf1",  {31'b0, port.overflow}, 32'h1);
    chk("fill_full2", {31'b0, port.in_full},  32'h1);
    for (int i = 1; i <= 4; i++) begin
      do_read(rv);
      chk($sformatf("fill_rd%0d", i), rv, 32'(i));
    end
    chk("fill_empty", {31'b0, port.in_valid}, 32'h0);

    // Push and pop on the same edge while full.
    do_clear();
    for (int i = 1; i <= 4; i++) send(32'(i));
    port.input_data = 32'h9;
    port.strobe     = 1'b1;
    step(1);
    port.strobe = 1'b0;
    step(1);
    port.InPortout = 1'b1;
    #1;
    chk("sim_head", port.BusMuxInInPortout, 32'h1);
    @(posedge Clock);
    #1;
    port.InPortout = 1'b0;
    chk("sim_full", {31'b0, port.in_full},  32'h1);
    chk("sim_ovf",  {31'b0, port.overflow}, 32'h0);
    step(2);
    for (int i = 0; i < 4; i++) begin
      do_read(rv);
      chk($sformatf("sim_rd%0d", i), rv, (i == 3) ? 32'h9 : 32'(i + 2));
    end

    // Underflow on empty read, then ten push/pop pairs across pointer wrap.
    do_clear();
    do_read(rv);
    chk("unf_bus_during", rv, 32'h0);
    chk("unf_flag",  {31'b0, port.underflow}, 32'h1);
    chk("unf_bus",   port.BusMuxInInPortout,  32'h0);
    for (int i = 0; i < 10; i++) begin
      send(32'hA0 + 32'(i));
      do_read(rv);
      chk($sformatf("wrap_rd%0d", i), rv, 32'hA0 + 32'(i));
    end
    chk("wrap_empty", {31'b0, port.in_valid}, 32'h0);
    chk("wrap_ovf",   {31'b0, port.overflow}, 32'h0);

    // Long strobe pushes exactly one word.
    do_clear();
    port.input_data = 32'hFFFFFFF4;
    port.strobe     = 1'b1;
    step(5);
    port.strobe = 1'b0;
    step(4);
    chk("long_valid", {31'b0, port.in_valid}, 32'h1);
    chk("long_full",  {31'b0, port.in_full},  32'h0);
    do_read(rv);
    chk("long_rd",    rv, 32'hFFFFFFF4);
    chk("long_empty", {31'b0, port.in_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
